// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the sequential FP datapath:
// field widths, canonical constants, FSM states and operand classification.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int EXT_W  = 27;

  localparam logic [31:0]      FP_NAN      = 32'h7F80_0001;
  localparam logic [31:0]      FP_POS_ZERO = 32'h0000_0000;
  localparam logic [EXP_W-1:0] FP_EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_SUB,
    ST_NORM,
    ST_DONE
  } fsm_state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[FRAC_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[FRAC_W-1:0] == '0);
  endfunction

  // Denormals are flushed, so a zero exponent alone marks a zero operand.
  function automatic logic is_zero_ftz(input logic [31:0] x);
    return x[30:23] == '0;
  endfunction

  function automatic logic [EXT_W-1:0] ext_mant(input logic [31:0] x);
    return is_zero_ftz(x) ? '0 : {1'b1, x[FRAC_W-1:0], 3'b000};
  endfunction

endpackage

// File: rtl/fp32_align_shift.sv
// Combinational 27-bit right barrel shifter used for exponent alignment;
// shift amounts of the full width or more saturate to an all-zero result.
module fp32_align_shift
  import fp32_pkg::*;
(
  input  logic [EXT_W-1:0] m_in,
  input  logic [EXP_W-1:0] shamt,
  output logic [EXT_W-1:0] m_out
);

  always_comb begin
    if (shamt >= EXP_W'(EXT_W)) begin
      m_out = '0;
    end else begin
      m_out = m_in >> shamt;
    end
  end

endmodule

// File: rtl/float_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (diff = a - b) with
// valid/ready handshakes and a one-shift-per-cycle normalization loop.
module float_sub_seq
  import fp32_pkg::*;
#(
  parameter int NORM_MAX = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        busy
);

  localparam int CNT_W = $clog2(NORM_MAX + 1);

  fsm_state_t       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXT_W:0]   man_q, man_d;
  logic [EXT_W-1:0] mans_q, mans_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      diff_q, diff_d;

  logic             a_larger;
  logic [31:0]      op_l, op_s;
  logic [EXP_W-1:0] shamt;
  logic [EXT_W-1:0] s_aligned;
  logic [EXT_W:0]   sum;
  logic [EXP_W-1:0] exp_inc, exp_dec;
  logic [EXT_W-1:0] shifted;

  fp32_align_shift u_align (
    .m_in  (ext_mant(op_s)),
    .shamt (shamt),
    .m_out (s_aligned)
  );

  // Datapath helpers evaluated every cycle; the FSM decides which one is used.
  always_comb begin
    a_larger  = (is_zero_ftz(a_q) ? 31'd0 : a_q[30:0]) >=
                (is_zero_ftz(b_q) ? 31'd0 : b_q[30:0]);
    op_l      = a_larger ? a_q : b_q;
    op_s      = a_larger ? b_q : a_q;
    shamt     = op_l[30:23] - op_s[30:23];
    sum       = sub_q ? (man_q - {1'b0, mans_q}) : (man_q + {1'b0, mans_q});
    exp_inc   = exp_q + 8'd1;
    exp_dec   = exp_q - 8'd1;
    shifted   = {man_q[EXT_W-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    man_d   = man_q;
    mans_d  = mans_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = {~b[31], b[30:0]};
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        state_d = ST_DONE;
        if (is_nan(a_q) || is_nan(b_q) ||
            (is_inf(a_q) && is_inf(b_q) && (a_q[31] != b_q[31]))) begin
          diff_d = FP_NAN;
        end else if (is_inf(a_q)) begin
          diff_d = {a_q[31], FP_EXP_MAX, 23'd0};
        end else if (is_inf(b_q)) begin
          diff_d = {b_q[31], FP_EXP_MAX, 23'd0};
        end else if (is_zero_ftz(a_q) && is_zero_ftz(b_q)) begin
          diff_d = FP_POS_ZERO;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        sign_d  = op_l[31];
        sub_d   = op_l[31] ^ op_s[31];
        exp_d   = op_l[30:23];
        man_d   = {1'b0, ext_mant(op_l)};
        mans_d  = s_aligned;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        state_d = ST_DONE;
        if (sum == '0) begin
          diff_d = FP_POS_ZERO;
        end else if (sum[EXT_W]) begin
          diff_d = (exp_inc == FP_EXP_MAX) ? {sign_q, FP_EXP_MAX, 23'd0}
                                           : {sign_q, exp_inc, sum[26:4]};
        end else if (sum[EXT_W-1]) begin
          diff_d = {sign_q, exp_q, sum[25:3]};
        end else begin
          man_d   = sum;
          cnt_d   = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        // Underflow to zero wins even when this shift would have normalized.
        if ((exp_dec == '0) || (cnt_q >= CNT_W'(NORM_MAX))) begin
          diff_d  = FP_POS_ZERO;
          state_d = ST_DONE;
        end else if (shifted[EXT_W-1]) begin
          diff_d  = {sign_q, exp_dec, shifted[25:3]};
          state_d = ST_DONE;
        end else begin
          man_d = {1'b0, shifted};
          exp_d = exp_dec;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      mans_q  <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      mans_q  <= mans_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign diff      = diff_q;

endmodule

// File: tb/tb_float_sub_seq.sv
// Scoreboard bench for float_sub_seq: directed plan cases plus randomized
// operands checked against a plain-arithmetic reference subtractor.
module tb_float_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] diff;
  logic        busy;

  float_sub_seq #(.NORM_MAX(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_diff;
    int          exp_lat;
    int          acc;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  bit    rand_ready = 1'b0;
  bit    force_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, expv);
  endtask

  // Reference subtractor: align with three guard bits, add or subtract
  // magnitudes, then normalize with a loop counting the left shifts taken.
  function automatic void refModel(input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] d, output int lat);
    logic [31:0] bn;
    int      ea, eb, el, es, e, k;
    longint  ma, mb, ml, ms, r;
    bit      sa, sb, sl, ss, nana, nanb, infa, infb;
    bn   = {~bv[31], bv[30:0]};
    sa   = av[31];
    sb   = bn[31];
    ea   = int'(av[30:23]);
    eb   = int'(bn[30:23]);
    nana = (ea == 255) && (av[22:0] != 0);
    nanb = (eb == 255) && (bn[22:0] != 0);
    infa = (ea == 255) && (av[22:0] == 0);
    infb = (eb == 255) && (bn[22:0] == 0);
    lat  = 2;
    if (nana || nanb || (infa && infb && sa != sb)) d = 32'h7F800001;
    else if (infa) d = {sa, 8'hFF, 23'h0};
    else if (infb) d = {sb, 8'hFF, 23'h0};
    else if (ea == 0 && eb == 0) d = 32'h0;
    else begin
      lat = 4;
      ma  = (ea == 0) ? 0 : (longint'(av[22:0]) + 64'd8388608) * 8;
      mb  = (eb == 0) ? 0 : (longint'(bn[22:0]) + 64'd8388608) * 8;
      if (ea > eb || (ea == eb && ma >= mb)) begin
        el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
      end else begin
        el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
      end
      if (el - es >= 27) ms = 0;
      else ms = ms >> (el - es);
      e = el;
      if (sl == ss) begin
        r = ml + ms;
        if (r >= 64'd134217728) begin
          r = r / 2;
          e = e + 1;
        end
        if (e == 255) d = {sl, 8'hFF, 23'h0};
        else d = {sl, 8'(e), 23'(r >> 3)};
      end else begin
        r = ml - ms;
        if (r == 0) d = 32'h0;
        else begin
          k = 0;
          while (r < 64'd67108864) begin
            r = r * 2;
            e = e - 1;
            k = k + 1;
            if (e == 0) break;
          end
          lat = 4 + k;
          if (e == 0) d = 32'h0;
          else d = {sl, 8'(e), 23'(r >> 3)};
        end
      end
    end
  endfunction

  // Present operands at a negedge and hold them until the DUT accepts;
  // acc is the number of the accepting clock edge, or -1 on timeout.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int acc);
    int n;
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("[TB] FAIL accept timeout: a=%h b=%h in_ready stayed 0, expected 1", av, bv);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] expd, input int explat);
    int    acc;
    item_t it;
    issue(av, bv, acc);
    if (acc >= 0) begin
      it.a = av; it.b = bv; it.exp_diff = expd; it.exp_lat = explat; it.acc = acc;
      sbq.push_back(it);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain pending results", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Monitor: compares every delivered result against the scoreboard head.
  bit          seen = 1'b0;
  int          first_cyc = 0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (seen) checkOutput("out_valid held until taken", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_cyc = cyc + 1;
          held = diff;
        end else begin
          checkOutput("diff stable while stalled", diff, held);
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            $display("[TB] FAIL unexpected output: got diff=%h, expected no result", diff);
          end else begin
            it = sbq.pop_front();
            checkOutput($sformatf("diff a=%h b=%h", it.a, it.b), diff, it.exp_diff);
            checkOutput($sformatf("latency a=%h b=%h", it.a, it.b),
                        32'(first_cyc - it.acc), 32'(it.exp_lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb, rd, pool[8];
    int          rl, acc, n, mode, ea, eb;
    pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
             32'h7FC00000, 32'h00000123, 32'h3F800000, 32'hC0400000};

    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset diff", diff, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h40400000, 32'h3F800000, 32'h40000000, 4);
    waitDrain();
    applyStimulus(32'h3F800000, 32'hBF800000, 32'h40000000, 4);
    waitDrain();
    applyStimulus(32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 28);
    waitDrain();
    applyStimulus(32'h7F800000, 32'h7F800000, 32'h7F800001, 2);
    waitDrain();

    // Abort the long cancellation case partway through normalization.
    issue(32'h3F800000, 32'h3F7FFFFF, acc);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort diff", diff, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'h40400000, 32'h3F800000, 32'h40000000, 4);
    waitDrain();

    // Stall the consumer and poke in_valid while the result waits.
    force_ready = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(32'h3F800000, 32'h3F800000, 32'h00000000, 4);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall result ready", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 32'h40400000;
      b = 32'h3F800000;
      in_valid = (i % 2 == 0);
      @(negedge clk);
      checkOutput("stall out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall diff", diff, 32'h0);
      checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall busy", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    force_ready = 1'b1;
    waitDrain();
    repeat (6) @(negedge clk);
    checkOutput("idle after stall", {31'd0, in_ready}, 32'd1);
    checkOutput("no extra op after stall", {31'd0, busy}, 32'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      case (mode)
        0: ;
        1, 2, 3: begin
          ea = $urandom_range(1, 254);
          eb = ea + $urandom_range(0, 6) - 3;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
          ra[30:23] = 8'(ea);
          rb[30:23] = 8'(eb);
          if (mode == 3) begin
            rb[30:0] = ra[30:0] ^ 31'($urandom_range(0, 15));
            rb[31] = ra[31];
          end
        end
        4: begin
          ra[30:23] = 8'($urandom_range(1, 30));
          rb[30:23] = ra[30:23];
          rb[31] = ra[31];
        end
        5: begin
          ra[30:23] = 8'($urandom_range(1, 8));
          rb[30:23] = 8'($urandom_range(1, 8));
        end
        6: begin
          ra[30:23] = 8'($urandom_range(250, 254));
          rb[30:23] = 8'($urandom_range(250, 254));
          rb[31] = ~ra[31];
        end
        default: begin
          if ($urandom_range(0, 1) == 1) ra = pool[$urandom_range(0, 7)];
          rb = pool[$urandom_range(0, 7)];
        end
      endcase
      refModel(ra, rb, rd, rl);
      applyStimulus(ra, rb, rd, rl);
    end
    waitDrain();
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
